amm_mem_model: RTL and testbench

Synthesizable Avalon-MM burst slave with internal RAM that sits directly downstream of `mem_checker`, terminating its `mem_*` master port. It accepts write and read bursts, applies byte enables, returns read data with a fixed pipeline latency, and optionally stalls with pseudo-random `waitrequest_o`. It lets the checker run closed-loop in simulation and on FPGA without an external memory controller.

---
 rtl/amm_mem_model.sv | 147 ++++++++++++++
 tb/tb_amm_mem_model.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_mem_model.sv
// Avalon-MM burst slave with internal RAM, byte enables, fixed read latency and optional random stalls.
// Define AMM_MEM_MODEL_ERR_INJECT_EN to add read-data bit-0 error injection on one word.
module amm_mem_model #(
    parameter int AMM_DATA_W  = 64,
    parameter int AMM_ADDR_W  = 28,
    parameter int AMM_BURST_W = 11,
    parameter int MEM_ADDR_W  = 10,
    parameter int RD_LATENCY  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AMM_ADDR_W-1:0]   address_i,
    input  logic                    read_i,
    input  logic                    write_i,
    input  logic [AMM_DATA_W-1:0]   writedata_i,
    input  logic [AMM_BURST_W-1:0]  burstcount_i,
    input  logic [AMM_DATA_W/8-1:0] byteenable_i,
    input  logic                    stall_en_i,
`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
    input  logic                    err_inj_en_i,
    input  logic [MEM_ADDR_W-1:0]   err_inj_addr_i,
`endif
    output logic                    waitrequest_o,
    output logic                    readdatavalid_o,
    output logic [AMM_DATA_W-1:0]   readdata_o,
    output logic [31:0]             wr_beats_o,
    output logic [31:0]             rd_beats_o
);
    localparam int BE_W = AMM_DATA_W / 8;
    localparam int STG  = RD_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  r_state, w_state_nxt;
    logic [MEM_ADDR_W-1:0]   r_addr, w_addr_nxt, w_wr_addr;
    logic [AMM_BURST_W-1:0]  r_remain, w_remain_nxt, w_len;
    logic                    w_wr_acc, w_rd_acc, w_ram_we, w_rd_issue;
    logic [15:0]             r_lfsr, w_lfsr_nxt;
    logic                    r_waitreq;
    logic [STG-1:0]          r_vld;
    logic [AMM_DATA_W-1:0]   r_dat [STG];
    logic [AMM_DATA_W-1:0]   r_mem [2**MEM_ADDR_W];
    logic [AMM_DATA_W-1:0]   w_rd_flip;
    logic [31:0]             r_wr_beats, r_rd_beats;
    logic                    w_unused;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign w_unused   = ^address_i[AMM_ADDR_W-1:MEM_ADDR_W];
    assign w_len      = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
    assign w_wr_acc   = write_i && !r_waitreq;
    assign w_rd_acc   = read_i && !write_i && !r_waitreq && (r_state == IDLE);
    assign w_lfsr_nxt = lfsr_step(r_lfsr);

`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
    assign w_rd_flip = (err_inj_en_i && (r_addr == err_inj_addr_i)) ? AMM_DATA_W'(1) : '0;
`else
    assign w_rd_flip = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        w_wr_addr    = r_addr;
        w_ram_we     = 1'b0;
        w_rd_issue   = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_addr = address_i[MEM_ADDR_W-1:0];
                if (w_wr_acc) begin
                    w_ram_we     = 1'b1;
                    w_addr_nxt   = address_i[MEM_ADDR_W-1:0] + MEM_ADDR_W'(1);
                    w_remain_nxt = w_len - AMM_BURST_W'(1);
                    if (w_len != AMM_BURST_W'(1)) w_state_nxt = WR_BURST;
                end else if (w_rd_acc) begin
                    w_addr_nxt   = address_i[MEM_ADDR_W-1:0];
                    w_remain_nxt = w_len;
                    w_state_nxt  = RD_BURST;
                end
            end
            WR_BURST: begin
                if (w_wr_acc) begin
                    w_ram_we     = 1'b1;
                    w_addr_nxt   = r_addr + MEM_ADDR_W'(1);
                    w_remain_nxt = r_remain - AMM_BURST_W'(1);
                    if (r_remain == AMM_BURST_W'(1)) w_state_nxt = IDLE;
                end
            end
            RD_BURST: begin
                w_rd_issue   = 1'b1;
                w_addr_nxt   = r_addr + MEM_ADDR_W'(1);
                w_remain_nxt = r_remain - AMM_BURST_W'(1);
                if (r_remain == AMM_BURST_W'(1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control path; waitrequest is precomputed from next state so it leaves a flop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_lfsr     <= 16'hACE1;
            r_waitreq  <= 1'b1;
            r_vld      <= '0;
            r_wr_beats <= '0;
            r_rd_beats <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_remain  <= w_remain_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_waitreq <= (w_state_nxt == RD_BURST) || (stall_en_i && w_lfsr_nxt[0]);
            r_vld[0]  <= w_rd_issue;
            for (int i = 1; i < STG; i++) r_vld[i] <= r_vld[i-1];
            if (w_ram_we) r_wr_beats <= sat_inc(r_wr_beats);
            if (r_vld[STG-1]) r_rd_beats <= sat_inc(r_rd_beats);
        end
    end

    // RAM and read-data delay line; data is qualified by r_vld, so no reset here.
    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable_i[b]) r_mem[w_wr_addr][8*b +: 8] <= writedata_i[8*b +: 8];
            end
        end
        r_dat[0] <= r_mem[r_addr] ^ w_rd_flip;
        for (int i = 1; i < STG; i++) r_dat[i] <= r_dat[i-1];
    end

    assign waitrequest_o   = r_waitreq;
    assign readdatavalid_o = r_vld[STG-1];
    assign readdata_o      = r_vld[STG-1] ? r_dat[STG-1] : '0;
    assign wr_beats_o      = r_wr_beats;
    assign rd_beats_o      = r_rd_beats;

endmodule

// File: tb/tb_amm_mem_model.sv
// Randomized self-checking bench for amm_mem_model against a word-array reference model.
module tb_amm_mem_model;
    localparam int DW = 64, AW = 28, BW = 11, MAW = 10, LAT = 4, DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  address_i = '0;
    logic           read_i = 1'b0, write_i = 1'b0, stall_en_i = 1'b0;
    logic [DW-1:0]  writedata_i = '0;
    logic [BW-1:0]  burstcount_i = '0;
    logic [7:0]     byteenable_i = '0;
    logic           waitrequest_o, readdatavalid_o;
    logic [DW-1:0]  readdata_o;
    logic [31:0]    wr_beats_o, rd_beats_o;
`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
    logic           ei_en = 1'b0;
    logic [MAW-1:0] ei_addr = '0;
`endif

    int vectors = 0, miscompares = 0;
    int exp_wr = 0, exp_rd = 0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] wq[$];
    logic [7:0]    beq[$];

    always #5 clk = ~clk;

    amm_mem_model #(.AMM_DATA_W(DW), .AMM_ADDR_W(AW), .AMM_BURST_W(BW),
                    .MEM_ADDR_W(MAW), .RD_LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .writedata_i(writedata_i), .burstcount_i(burstcount_i),
        .byteenable_i(byteenable_i), .stall_en_i(stall_en_i),
`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
        .err_inj_en_i(ei_en), .err_inj_addr_i(ei_addr),
`endif
        .waitrequest_o(waitrequest_o), .readdatavalid_o(readdatavalid_o),
        .readdata_o(readdata_o), .wr_beats_o(wr_beats_o), .rd_beats_o(rd_beats_o));

    function automatic logic [DW-1:0] model_read(input int a);
        logic [DW-1:0] d;
        d = mem_m[a % DEPTH];
`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
        if (ei_en && (int'(ei_addr) == a % DEPTH)) d[0] = ~d[0];
`endif
        return d;
    endfunction

    task automatic model_write(input int a, input logic [DW-1:0] d, input logic [7:0] be);
        for (int b = 0; b < 8; b++)
            if (be[b]) mem_m[a % DEPTH][8*b +: 8] = d[8*b +: 8];
    endtask

    // Wait (bounded) for waitrequest low so the next edge accepts; 1 on success.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!waitrequest_o) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wr_burst(input int addr, input int bc, input bit gaps, input string tag);
        int len;
        bit ok;
        len = (bc == 0) ? 1 : bc;
        for (int k = 0; k < len; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin write_i = 1'b0; @(posedge clk); #1; end
            end
            write_i      = 1'b1;
            address_i    = (k == 0) ? AW'(addr) : AW'($urandom);
            burstcount_i = (k == 0) ? BW'(bc) : BW'($urandom);
            writedata_i  = wq[k];
            byteenable_i = beq[k];
            wait_accept(ok);
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL %s accept beat %0d: waitrequest stuck, required accept", tag, k);
                write_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            model_write(addr + k, wq[k], beq[k]);
            exp_wr++;
        end
        write_i = 1'b0;
    endtask

    task automatic rd_burst(input int addr, input int bc, input string tag);
        int len;
        bit ok, exp_v;
        logic [DW-1:0] expd;
        len = (bc == 0) ? 1 : bc;
        read_i = 1'b1; address_i = AW'(addr); burstcount_i = BW'(bc);
        wait_accept(ok);
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL %s read accept: waitrequest stuck, required accept", tag);
            read_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        read_i = 1'b0; address_i = AW'($urandom); burstcount_i = BW'($urandom);
        for (int j = 1; j <= LAT + len; j++) begin
            @(negedge clk);
            exp_v = (j >= LAT) && (j < LAT + len);
            vectors++;
            if (readdatavalid_o !== exp_v) begin
                miscompares++;
                $display("FAIL %s valid @T+%0d: got %b required %b", tag, j, readdatavalid_o, exp_v);
            end
            if (exp_v) begin
                expd = model_read(addr + j - LAT);
                exp_rd++;
                vectors++;
                if (readdata_o !== expd) begin
                    miscompares++;
                    $display("FAIL %s data beat %0d: got %h required %h", tag, j - LAT, readdata_o, expd);
                end
            end
            if (j <= len) begin
                vectors++;
                if (waitrequest_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s waitreq @T+%0d: got %b required 1", tag, j, waitrequest_o);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_counters(input string tag);
        vectors++;
        if (wr_beats_o !== 32'(exp_wr)) begin
            miscompares++;
            $display("FAIL %s wr_beats: got %0d required %0d", tag, wr_beats_o, exp_wr);
        end
        vectors++;
        if (rd_beats_o !== 32'(exp_rd)) begin
            miscompares++;
            $display("FAIL %s rd_beats: got %0d required %0d", tag, rd_beats_o, exp_rd);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if (waitrequest_o !== 1'b1 || readdatavalid_o !== 1'b0 || readdata_o !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got wr=%b vld=%b data=%h required 1 0 0",
                     waitrequest_o, readdatavalid_o, readdata_o);
        end
        check_counters("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (waitrequest_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset release waitreq: got %b required 0", waitrequest_o);
        end
    endtask

    task automatic test_single;
        wq = '{64'h0123_4567_89AB_CDEF}; beq = '{8'hFF};
        wr_burst(5, 1, 1'b0, "single_wr");
        rd_burst(5, 1, "single_rd");
        check_counters("single");
    endtask

    task automatic test_byte_enable;
        wq = '{64'hFFFF_FFFF_FFFF_FFFF}; beq = '{8'hFF};
        wr_burst(7, 1, 1'b0, "be_full");
        wq = '{64'h0}; beq = '{8'h0F};
        wr_burst(7, 1, 1'b0, "be_low");
        rd_burst(7, 1, "be_rd");
        wq = '{64'h1234_5678_9ABC_DEF0}; beq = '{8'h00};
        wr_burst(7, 1, 1'b0, "be_none");
        rd_burst(7, 1, "be_none_rd");
        check_counters("be");
    endtask

    task automatic test_wrap;
        wq = '{64'd1, 64'd2, 64'd3, 64'd4}; beq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wr_burst(1022, 4, 1'b0, "wrap_wr");
        rd_burst(1022, 4, "wrap_rd");
    endtask

    task automatic test_len0_and_priority;
        bit ok;
        wq = '{64'hAAAA_0000_0000_0021}; beq = '{8'hFF};
        wr_burst(21, 1, 1'b0, "len0_pre");
        wq = '{64'hAAAA_0000_0000_0020}; wr_burst(20, 0, 1'b0, "len0_a");
        wq = '{64'hAAAA_0000_0000_0030}; wr_burst(30, 0, 1'b0, "len0_b");
        rd_burst(20, 2, "len0_rd");
        rd_burst(30, 0, "len0_rd30");
        write_i = 1'b1; read_i = 1'b1; address_i = AW'(40); burstcount_i = BW'(1);
        writedata_i = 64'h5555_6666_7777_8888; byteenable_i = 8'hFF;
        wait_accept(ok);
        @(posedge clk); #1;
        write_i = 1'b0; read_i = 1'b0;
        model_write(40, 64'h5555_6666_7777_8888, 8'hFF);
        exp_wr++;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            vectors++;
            if (readdatavalid_o !== 1'b0 || waitrequest_o !== 1'b0) begin
                miscompares++;
                $display("FAIL write_wins cyc %0d: got vld=%b wr=%b required 0 0",
                         j, readdatavalid_o, waitrequest_o);
            end
        end
        @(posedge clk); #1;
        rd_burst(40, 1, "write_wins_rd");
        check_counters("len0");
    endtask

    task automatic test_random;
        int len, base, rl, ra;
        wq.delete(); beq.delete();
        for (int i = 0; i < 32; i++) begin wq.push_back({$urandom, $urandom}); beq.push_back(8'hFF); end
        wr_burst(100, 32, 1'b0, "fill");
        rd_burst(100, 32, "fill_rd");
        for (int it = 0; it < 8; it++) begin
            stall_en_i = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 6);
            base = 100 + $urandom_range(0, 32 - len) + DEPTH * $urandom_range(0, 3);
            wq.delete(); beq.delete();
            for (int i = 0; i < len; i++) begin wq.push_back({$urandom, $urandom}); beq.push_back(8'($urandom)); end
            wr_burst(base, len, 1'b1, "rand_wr");
            rl = $urandom_range(1, 8);
            ra = 100 + $urandom_range(0, 32 - rl);
            rd_burst(ra, rl, "rand_rd");
        end
        stall_en_i = 1'b0;
        check_counters("random");
    endtask

    task automatic test_stalls;
        int base;
        stall_en_i = 1'b1;
        base = 300 + $urandom_range(0, 200);
        wq.delete(); beq.delete();
        for (int i = 0; i < 16; i++) begin wq.push_back({$urandom, $urandom}); beq.push_back(8'hFF); end
        wr_burst(base, 16, 1'b1, "stall_wr");
        rd_burst(base, 16, "stall_rd");
        stall_en_i = 1'b0;
        check_counters("stalls");
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        read_i = 1'b1; address_i = AW'(100); burstcount_i = BW'(8);
        wait_accept(ok);
        @(posedge clk); #1;
        read_i = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (waitrequest_o !== 1'b1 || readdatavalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset outputs: got wr=%b vld=%b required 1 0", waitrequest_o, readdatavalid_o);
        end
        exp_wr = 0; exp_rd = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            vectors++;
            if (readdatavalid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset flush cyc %0d: got vld=%b required 0", j, readdatavalid_o);
            end
        end
        check_counters("midreset");
        @(posedge clk); #1;
        rd_burst(5, 1, "midreset_rd5");
        rd_burst(100, 2, "midreset_rd100");
        check_counters("midreset_after");
    endtask

`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
    task automatic test_err_inject;
        wq = '{64'h10, 64'h20}; beq = '{8'hFF, 8'hFF};
        wr_burst(5, 2, 1'b0, "ei_wr");
        ei_en = 1'b1; ei_addr = MAW'(5);
        rd_burst(5, 1, "ei_rd5");
        rd_burst(6, 1, "ei_rd6");
        rd_burst(4, 3, "ei_rd_burst");
        ei_en = 1'b0;
        rd_burst(5, 1, "ei_off_rd5");
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_byte_enable();
        test_wrap();
        test_len0_and_priority();
        test_random();
        test_stalls();
        test_reset_mid_read();
`ifdef AMM_MEM_MODEL_ERR_INJECT_EN
        test_err_inject();
`endif
        check_counters("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
